// File: rtl/dm_read_cache_if.sv
// CPU request/response and main-memory block-fetch signals of dm_read_cache.
// master = CPU + memory side (bench/system), slave = the cache.
interface dm_read_cache_if #(
  parameter int ADDR_W   = 15,
  parameter int OFFSET_W = 2,
  parameter int WORD_W   = 32,
  parameter int CNT_W    = 14
) ();
  logic                               cache_read;
  logic                               cache_write;
  logic [ADDR_W-1:0]                  address;
  logic                               cache_ready;
  logic [WORD_W-1:0]                  data_out;
  logic [CNT_W-1:0]                   hit_count;
  logic                               mem_read;
  logic [ADDR_W-OFFSET_W-1:0]         mem_addr;
  logic                               mem_ready;
  logic [(1<<OFFSET_W)*WORD_W-1:0]    mem_data;

  modport master (
    output cache_read, cache_write, address, mem_ready, mem_data,
    input  cache_ready, data_out, hit_count, mem_read, mem_addr
  );

  modport slave (
    input  cache_read, cache_write, address, mem_ready, mem_data,
    output cache_ready, data_out, hit_count, mem_read, mem_addr
  );
endinterface

// File: rtl/dm_read_cache.sv
// Direct-mapped read-allocate cache: 4-word blocks fetched from main memory on a miss.
// Optional DM_CACHE_MISS_STATS_EN adds miss_count and fill_busy outputs.
module dm_read_cache #(
  parameter int ADDR_W   = 15,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 2,
  parameter int WORD_W   = 32,
  parameter int CNT_W    = 14
) (
  input  logic              clk,
  input  logic              rst,
  dm_read_cache_if.slave    bus
`ifdef DM_CACHE_MISS_STATS_EN
  ,
  output logic [CNT_W-1:0]  miss_count,
  output logic              fill_busy
`endif
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {IDLE, COMPARE, FETCH, RESP} state_t;
  typedef logic [WORDS-1:0][WORD_W-1:0] block_t;

  state_t                      state;
  logic [ADDR_W-1:0]           req_addr;
  logic                        req_write;
  logic [LINES-1:0]            valid;
  logic [TAG_W-1:0]            tag_mem  [LINES];
  block_t                      data_mem [LINES];

  logic                        ready_q;
  logic [WORD_W-1:0]           data_q;
  logic [CNT_W-1:0]            hits_q;
  logic                        mem_read_q;
  logic [ADDR_W-OFFSET_W-1:0]  mem_addr_q;

  logic [OFFSET_W-1:0]         req_off;
  logic [INDEX_W-1:0]          req_idx;
  logic [TAG_W-1:0]            req_tag;
  logic                        line_hit;
  block_t                      line_words;
  block_t                      fill_words;

  assign req_off    = req_addr[OFFSET_W-1:0];
  assign req_idx    = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign req_tag    = req_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign line_hit   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign line_words = data_mem[req_idx];
  assign fill_words = bus.mem_data;

  assign bus.cache_ready = ready_q;
  assign bus.data_out    = data_q;
  assign bus.hit_count   = hits_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_addr    = mem_addr_q;

`ifdef DM_CACHE_MISS_STATS_EN
  assign fill_busy = (state == FETCH);
`endif

  // Write ack is routed through COMPARE so it sees the same 2-cycle latency as a hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_write  <= 1'b0;
      valid      <= '0;
      ready_q    <= 1'b0;
      data_q     <= '0;
      hits_q     <= '0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
`ifdef DM_CACHE_MISS_STATS_EN
      miss_count <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cache_read) begin
            req_addr  <= bus.address;
            req_write <= 1'b0;
            state     <= COMPARE;
          end else if (bus.cache_write) begin
            req_write <= 1'b1;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (req_write) begin
            ready_q <= 1'b1;
            state   <= RESP;
          end else if (line_hit) begin
            if (hits_q != '1) hits_q <= hits_q + 1'b1;
            data_q  <= line_words[req_off];
            ready_q <= 1'b1;
            state   <= RESP;
          end else begin
            mem_read_q <= 1'b1;
            mem_addr_q <= req_addr[ADDR_W-1:OFFSET_W];
`ifdef DM_CACHE_MISS_STATS_EN
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
`endif
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (bus.mem_ready) begin
            valid[req_idx] <= 1'b1;
            data_q         <= fill_words[req_off];
            mem_read_q     <= 1'b0;
            ready_q        <= 1'b1;
            state          <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (rst && (state == FETCH) && bus.mem_ready) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= fill_words;
    end
  end
endmodule
